// File: rtl/mips_cpu_pkg.sv
// ============================================================================
// Module   : mips_cpu_pkg
// Brief    : Shared types and encodings for the multi-cycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLLV = 5'd9;
  localparam logic [4:0] ALU_SRLV = 5'd10;
  localparam logic [4:0] ALU_SRAV = 5'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] PC_SRC_PC4    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;

  localparam logic [1:0] SRC_B_RT   = 2'd0;
  localparam logic [1:0] SRC_B_SEXT = 2'd1;
  localparam logic [1:0] SRC_B_ZEXT = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mips_cpu_alu_decode.sv
// ============================================================================
// Module   : mips_cpu_alu_decode
// Brief    : Combinational opcode/funct decode to ALU op, operand-B select
//            and a legality flag for every instruction the CPU supports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_alu_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [4:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       legal
);

  always_comb begin
    alu_op    = ALU_AND;
    alu_src_b = SRC_B_RT;
    legal     = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_SLTU: alu_op = ALU_SLTU;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_SLLV: alu_op = ALU_SLLV;
          FN_SRLV: alu_op = ALU_SRLV;
          FN_SRAV: alu_op = ALU_SRAV;
          FN_JR:   alu_op = ALU_AND;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDIU: begin alu_op = ALU_ADD;  alu_src_b = SRC_B_SEXT; end
      OP_ANDI:  begin alu_op = ALU_AND;  alu_src_b = SRC_B_ZEXT; end
      OP_ORI:   begin alu_op = ALU_OR;   alu_src_b = SRC_B_ZEXT; end
      OP_XORI:  begin alu_op = ALU_XOR;  alu_src_b = SRC_B_ZEXT; end
      OP_SLTIU: begin alu_op = ALU_SLTU; alu_src_b = SRC_B_SEXT; end
      OP_LW, OP_SW: begin alu_op = ALU_ADD; alu_src_b = SRC_B_SEXT; end
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; alu_src_b = SRC_B_RT; end
      OP_J:     alu_op = ALU_AND;
      default:  legal  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_cpu_alu_ctrl_fsm.sv
// ============================================================================
// Module   : mips_cpu_alu_ctrl_fsm
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the ALU op
//            interface, memory handshake and datapath enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_cpu_alu_ctrl_fsm
  import mips_cpu_pkg::*;
#(
  parameter logic        RESET_ACTIVE = 1'b1,
  parameter logic [31:0] HALT_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic        alu_zero,
  input  logic        mem_waitrequest,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [4:0]  alu_op,
  output logic [4:0]  alu_sa,
  output logic [1:0]  alu_src_b,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        active,
  output logic        illegal
);

  state_t     state;
  state_t     state_next;
  logic       active_next;
  logic       illegal_next;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] dec_alu_op;
  logic [1:0] dec_src_b;
  logic       dec_legal;

  logic       is_rtype, is_j, is_jr, is_beq, is_bne, is_lw, is_sw;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_j     = (opcode == OP_J);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign branch_taken = (is_beq && alu_zero) || (is_bne && !alu_zero);
  // Register specifiers and immediates are consumed by the datapath, not here.
  assign unused_instr_bits = ^instr[25:11];

  mips_cpu_alu_decode u_alu_decode (
    .opcode    (opcode),
    .funct     (funct),
    .alu_op    (dec_alu_op),
    .alu_src_b (dec_src_b),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_FETCH;
      active  <= RESET_ACTIVE;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      active  <= active_next;
      illegal <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state;
    active_next  = active;
    illegal_next = illegal;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PC4;
    alu_op       = ALU_AND;
    alu_sa       = 5'd0;
    alu_src_b    = SRC_B_RT;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    // Strobes are gated by reset so an in-flight transfer is dropped at once.
    if (reset_n) begin
      case (state)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (!mem_waitrequest) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            pc_src     = PC_SRC_PC4;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (!dec_legal) begin
            illegal_next = 1'b1;
            active_next  = 1'b0;
            state_next   = ST_HALT;
          end else if (is_j) begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            state_next = ST_FETCH;
          end else if (is_jr) begin
            if (rs_data == HALT_ADDR) begin
              active_next = 1'b0;
              state_next  = ST_HALT;
            end else begin
              pc_write   = 1'b1;
              pc_src     = PC_SRC_RS;
              state_next = ST_FETCH;
            end
          end else begin
            state_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          alu_sa    = instr[10:6];
          if (is_lw || is_sw) begin
            state_next = ST_MEM;
          end else if (is_beq || is_bne) begin
            pc_write   = branch_taken;
            pc_src     = branch_taken ? PC_SRC_BRANCH : PC_SRC_PC4;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end
        ST_MEM: begin
          // Address computation stays on the ALU for the whole transfer.
          alu_op    = dec_alu_op;
          alu_src_b = dec_src_b;
          alu_sa    = instr[10:6];
          mem_read  = is_lw;
          mem_write = !is_lw;
          if (!mem_waitrequest) begin
            state_next = is_lw ? ST_WB : ST_FETCH;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_rtype;
          mem_to_reg = is_lw;
          state_next = ST_FETCH;
        end
        ST_HALT: begin
          active_next = 1'b0;
        end
        default: begin
          state_next = ST_FETCH;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_cpu_alu_ctrl_fsm.sv
// ============================================================================
// Module   : tb_mips_cpu_alu_ctrl_fsm
// Brief    : Scoreboard bench: per-cycle expected outputs queued by the driver,
//            popped and compared on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_cpu_alu_ctrl_fsm;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [4:0] alu_op;
    logic [4:0] alu_sa;
    logic [1:0] alu_src_b;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       active;
    logic       illegal;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [31:0] rs_data = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_waitrequest = 1'b1;
  logic        mem_read, mem_write, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic [4:0]  alu_op, alu_sa;
  logic [1:0]  alu_src_b;
  logic        reg_dst, mem_to_reg, reg_write, active, illegal;

  outs_t       got;
  string       tag_q[$];
  outs_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  mips_cpu_alu_ctrl_fsm dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr           (instr),
    .rs_data         (rs_data),
    .alu_zero        (alu_zero),
    .mem_waitrequest (mem_waitrequest),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .alu_op          (alu_op),
    .alu_sa          (alu_sa),
    .alu_src_b       (alu_src_b),
    .reg_dst         (reg_dst),
    .mem_to_reg      (mem_to_reg),
    .reg_write       (reg_write),
    .active          (active),
    .illegal         (illegal)
  );

  always_comb got = {mem_read, mem_write, ir_write, pc_write, pc_src, alu_op, alu_sa,
                     alu_src_b, reg_dst, mem_to_reg, reg_write, active, illegal};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) check(tag_q.pop_front(), {9'd0, got}, {9'd0, exp_q.pop_front()});
  end

  function automatic outs_t idle(input logic act, input logic ill);
    outs_t o = '0;
    o.active  = act;
    o.illegal = ill;
    return o;
  endfunction

  task automatic step(input string t, input logic rn, input logic [31:0] ins,
                      input logic [31:0] rs, input logic z, input logic wr, input outs_t e);
    @(posedge clk);
    #1;
    reset_n = rn; instr = ins; rs_data = rs; alu_zero = z; mem_waitrequest = wr;
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic do_fetch(input string t, input logic [31:0] ins, input int waits);
    outs_t e;
    for (int k = 0; k < waits; k++) begin
      e = idle(1'b1, 1'b0); e.mem_read = 1'b1;
      step({t, ".fwait"}, 1'b1, ins, 32'h0, 1'b0, 1'b1, e);
    end
    e = idle(1'b1, 1'b0); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step({t, ".fetch"}, 1'b1, ins, 32'h0, 1'b0, 1'b0, e);
  endtask

  task automatic alu_instr(input string t, input logic [31:0] ins, input int fwaits,
                           input logic [4:0] op, input logic [1:0] sb, input logic [4:0] sa,
                           input logic rd);
    outs_t e;
    do_fetch(t, ins, fwaits);
    e = idle(1'b1, 1'b0);
    step({t, ".dec"}, 1'b1, ins, 32'h0, 1'b0, 1'b1, e);
    e = idle(1'b1, 1'b0); e.alu_op = op; e.alu_src_b = sb; e.alu_sa = sa;
    step({t, ".exec"}, 1'b1, ins, 32'h0, 1'b0, 1'b1, e);
    e = idle(1'b1, 1'b0); e.reg_write = 1'b1; e.reg_dst = rd;
    step({t, ".wb"}, 1'b1, ins, 32'h0, 1'b0, 1'b1, e);
  endtask

  task automatic branch(input string t, input logic [31:0] ins, input logic z, input logic taken);
    outs_t e;
    do_fetch(t, ins, 0);
    e = idle(1'b1, 1'b0);
    step({t, ".dec"}, 1'b1, ins, 32'h0, z, 1'b1, e);
    e = idle(1'b1, 1'b0); e.alu_op = 5'd3; e.pc_write = taken; e.pc_src = taken ? 2'd1 : 2'd0;
    step({t, ".exec"}, 1'b1, ins, 32'h0, z, 1'b1, e);
  endtask

  initial begin
    outs_t e;
    // Reset, then a second reset in the middle of a stalled fetch.
    e = idle(1'b1, 1'b0);
    step("rst_hold0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e);
    step("rst_hold1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e);
    e.mem_read = 1'b1;
    step("fetch_stall0", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, e);
    step("fetch_stall1", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, e);
    e = idle(1'b1, 1'b0);
    step("rst_mid_fetch", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e);
    e.mem_read = 1'b1;
    step("post_rst_read", 1'b1, 32'h0, 32'h0, 1'b0, 1'b1, e);

    alu_instr("addu", 32'h00221821, 0, 5'd2, 2'd0, 5'd0, 1'b1);
    alu_instr("sra",  32'h00011143, 2, 5'd8, 2'd0, 5'd5, 1'b1);
    alu_instr("sllv", 32'h00221004, 0, 5'd9, 2'd0, 5'd0, 1'b1);
    alu_instr("andi", 32'h3022000F, 0, 5'd0, 2'd2, 5'd0, 1'b0);
    alu_instr("sltiu", 32'h2C220005, 1, 5'd4, 2'd1, 5'd0, 1'b0);

    // LW with three stalled memory cycles: 8 cycles total.
    do_fetch("lw", 32'h8C220004, 0);
    e = idle(1'b1, 1'b0);
    step("lw.dec", 1'b1, 32'h8C220004, 32'h0, 1'b0, 1'b1, e);
    e.alu_op = 5'd2; e.alu_src_b = 2'd1;
    step("lw.exec", 1'b1, 32'h8C220004, 32'h0, 1'b0, 1'b1, e);
    e.mem_read = 1'b1;
    for (int k = 0; k < 4; k++)
      step("lw.mem", 1'b1, 32'h8C220004, 32'h0, 1'b0, (k < 3), e);
    e = idle(1'b1, 1'b0); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    step("lw.wb", 1'b1, 32'h8C220004, 32'h0, 1'b0, 1'b1, e);

    // SW with one stalled cycle, returns straight to FETCH.
    do_fetch("sw", 32'hAC220008, 0);
    e = idle(1'b1, 1'b0);
    step("sw.dec", 1'b1, 32'hAC220008, 32'h0, 1'b0, 1'b1, e);
    e.alu_op = 5'd2; e.alu_src_b = 2'd1;
    step("sw.exec", 1'b1, 32'hAC220008, 32'h0, 1'b0, 1'b1, e);
    e.mem_write = 1'b1;
    step("sw.mem0", 1'b1, 32'hAC220008, 32'h0, 1'b0, 1'b1, e);
    step("sw.mem1", 1'b1, 32'hAC220008, 32'h0, 1'b0, 1'b0, e);

    branch("beq_z1", 32'h10220003, 1'b1, 1'b1);
    branch("bne_z1", 32'h14220003, 1'b1, 1'b0);
    branch("bne_z0", 32'h14220003, 1'b0, 1'b1);
    branch("beq_z0", 32'h10220003, 1'b0, 1'b0);

    do_fetch("j", 32'h08000010, 0);
    e = idle(1'b1, 1'b0); e.pc_write = 1'b1; e.pc_src = 2'd2;
    step("j.dec", 1'b1, 32'h08000010, 32'h0, 1'b0, 1'b1, e);

    do_fetch("jr", 32'h03E00008, 0);
    e = idle(1'b1, 1'b0); e.pc_write = 1'b1; e.pc_src = 2'd3;
    step("jr.dec", 1'b1, 32'h03E00008, 32'h00000400, 1'b0, 1'b1, e);

    // JR to the halt address: CPU stops and never fetches again.
    do_fetch("jr_halt", 32'h03E00008, 0);
    e = idle(1'b1, 1'b0);
    step("jr_halt.dec", 1'b1, 32'h03E00008, 32'h0, 1'b0, 1'b1, e);
    e = idle(1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("halt", 1'b1, 32'h03E00008, 32'h0, 1'b0, 1'b0, e);

    e = idle(1'b1, 1'b0);
    step("rst_after_halt", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, e);
    do_fetch("ill", 32'hFC000000, 1);
    e = idle(1'b1, 1'b0);
    step("ill.dec", 1'b1, 32'hFC000000, 32'h0, 1'b0, 1'b1, e);
    e = idle(1'b0, 1'b1);
    step("ill.halt0", 1'b1, 32'hFC000000, 32'h0, 1'b0, 1'b0, e);
    step("ill.halt1", 1'b1, 32'hFC000000, 32'h0, 1'b0, 1'b0, e);
    e = idle(1'b1, 1'b0);
    step("rst_clears_illegal", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e);
    e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("restart_fetch", 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, e);

    repeat (3) @(negedge clk);
    check("queue_drain", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
